// File: rtl/fsm_nibble_host.sv
// fsm_nibble_host
//
// Host-side initiator for a 4-bit nibble-serial compute FSM. One wide
// command (two operands plus a short op_val sequence) is serialised onto
// the FSM pins as start / input_enable / nibble / op_val. The nibble-serial
// result is then collected while output_valid is high and returned as a
// single wide response.
//
// Every dut_* output is a registered value: it is computed from the current
// state and counters and loaded on the same edge as the state change, so no
// input reaches a dut_* pin combinationally.
//
// Optional feature (compile-time macro FSM_NIBBLE_HOST_TIMEOUT_EN):
//   defined     - WAIT is bounded to TIMEOUT cycles, after which the response
//                 returns with rsp_err=1 and rsp_data=0.
//   not defined - WAIT is unbounded; rsp_err is raised only by a short
//                 output burst.

module fsm_nibble_host #(
  parameter int N       = 64,   // operand / result width
  parameter int N_width = 4,    // nibble lane width
  parameter int OPS_MAX = 8,    // maximum op_val steps per command
  parameter int TIMEOUT = 1024  // WAIT bound when the timeout is enabled
) (
  input  logic                         clk,
  input  logic                         rst,

  // Command side
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [N-1:0]                 cmd_a,
  input  logic [N-1:0]                 cmd_b,
  input  logic [2*OPS_MAX-1:0]         cmd_op_seq,
  input  logic [$clog2(OPS_MAX+1)-1:0] cmd_op_len,
  input  logic [1:0]                   cmd_op_tail,

  // Compute FSM pins
  output logic                         dut_start,
  output logic                         dut_input_enable,
  output logic [N_width-1:0]           dut_a,
  output logic [N_width-1:0]           dut_b,
  output logic [1:0]                   dut_op_val,
  input  logic                         dut_output_valid,
  input  logic [N_width-1:0]           dut_out,

  // Response side
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [N-1:0]                 rsp_data,
  output logic                         rsp_err,

  output logic                         busy
);

  localparam int BEATS = N / N_width;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW    = $clog2(OPS_MAX + 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [OW-1:0] OPS_LIMIT = OW'(OPS_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_OPS,
    S_WAIT,
    S_COLLECT,
    S_RESP
  } state_t;

  // Control state and counters
  state_t                r_state;
  logic [BW-1:0]         r_beat;
  logic [OW-1:0]         r_op_idx;

  // Latched command
  logic [N-1:0]          r_a;
  logic [N-1:0]          r_b;
  logic [2*OPS_MAX-1:0]  r_op_seq;
  logic [OW-1:0]         r_op_len;
  logic [1:0]            r_op_tail;

  // Registered outputs
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_dut_start;
  logic                  r_dut_input_enable;
  logic [N_width-1:0]    r_dut_a;
  logic [N_width-1:0]    r_dut_b;
  logic [1:0]            r_dut_op_val;
  logic                  r_rsp_valid;
  logic [N-1:0]          r_rsp_data;
  logic                  r_rsp_err;

`ifdef FSM_NIBBLE_HOST_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0]         r_wait_cnt;
`endif

  // Requested op count, clamped to the sequence storage size
  logic [OW-1:0]         w_op_len_clamped;

  // Nibble k of a wide operand
  function automatic logic [N_width-1:0] beat_of(input logic [N-1:0] v,
                                                 input logic [BW-1:0] k);
    return v[int'(k)*N_width +: N_width];
  endfunction

  // Op i of the latched op sequence
  function automatic logic [1:0] op_of(input logic [2*OPS_MAX-1:0] seq,
                                       input logic [OW-1:0]        i);
    return seq[int'(i)*2 +: 2];
  endfunction

  assign w_op_len_clamped = (cmd_op_len > OPS_LIMIT) ? OPS_LIMIT : cmd_op_len;

  // Command sequencer: state, counters, latched command and all registered outputs
  // NOTE: every register here uses non-blocking assignment so that all
  // reads in this block see the pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state            <= S_IDLE;
      r_beat             <= '0;
      r_op_idx           <= '0;
      r_a                <= '0;
      r_b                <= '0;
      r_op_seq           <= '0;
      r_op_len           <= '0;
      r_op_tail          <= '0;
      r_cmd_ready        <= 1'b1;
      r_busy             <= 1'b0;
      r_dut_start        <= 1'b0;
      r_dut_input_enable <= 1'b0;
      r_dut_a            <= '0;
      r_dut_b            <= '0;
      r_dut_op_val       <= '0;
      r_rsp_valid        <= 1'b0;
      r_rsp_data         <= '0;
      r_rsp_err          <= 1'b0;
`ifdef FSM_NIBBLE_HOST_TIMEOUT_EN
      r_wait_cnt         <= '0;
`endif
    end else begin
      case (r_state)
        // Accept a command: snapshot every field and pulse start next cycle
        S_IDLE: begin
          if (cmd_valid) begin
            r_a          <= cmd_a;
            r_b          <= cmd_b;
            r_op_seq     <= cmd_op_seq;
            r_op_len     <= w_op_len_clamped;
            r_op_tail    <= cmd_op_tail;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_dut_start  <= 1'b1;
            r_state      <= S_START;
          end
        end

        // Single start cycle; present beat 0 on the lanes for the first LOAD cycle
        S_START: begin
          r_dut_start        <= 1'b0;
          r_dut_input_enable <= 1'b1;
          r_dut_a            <= beat_of(r_a, '0);
          r_dut_b            <= beat_of(r_b, '0);
          r_beat             <= '0;
          r_state            <= S_LOAD;
        end

        // Stream operand nibbles, least significant beat first
        S_LOAD: begin
          if (r_beat == LAST_BEAT) begin
            r_dut_input_enable <= 1'b0;
            r_dut_a            <= '0;
            r_dut_b            <= '0;
            r_beat             <= '0;
            if (r_op_len == '0) begin
              r_dut_op_val <= r_op_tail;
`ifdef FSM_NIBBLE_HOST_TIMEOUT_EN
              r_wait_cnt   <= '0;
`endif
              r_state      <= S_WAIT;
            end else begin
              r_op_idx     <= '0;
              r_dut_op_val <= op_of(r_op_seq, '0);
              r_state      <= S_OPS;
            end
          end else begin
            r_beat  <= r_beat + 1'b1;
            r_dut_a <= beat_of(r_a, r_beat + 1'b1);
            r_dut_b <= beat_of(r_b, r_beat + 1'b1);
          end
        end

        // One op per cycle, then hold the tail op while waiting for output
        S_OPS: begin
          if (r_op_idx == r_op_len - 1'b1) begin
            r_dut_op_val <= r_op_tail;
`ifdef FSM_NIBBLE_HOST_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
            r_state      <= S_WAIT;
          end else begin
            r_op_idx     <= r_op_idx + 1'b1;
            r_dut_op_val <= op_of(r_op_seq, r_op_idx + 1'b1);
          end
        end

        // The first valid cycle already carries result beat 0
        S_WAIT: begin
          if (dut_output_valid) begin
            r_rsp_data[N_width-1:0] <= dut_out;
            if (BEATS == 1) begin
              r_dut_op_val <= '0;
              r_rsp_valid  <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_beat  <= BW'(1);
              r_state <= S_COLLECT;
            end
          end
`ifdef FSM_NIBBLE_HOST_TIMEOUT_EN
          else if (r_wait_cnt == WAIT_LAST) begin
            r_rsp_err    <= 1'b1;
            r_rsp_data   <= '0;
            r_dut_op_val <= '0;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end

        // Gather the remaining beats; a gap in the burst aborts with an error
        S_COLLECT: begin
          if (dut_output_valid) begin
            r_rsp_data[int'(r_beat)*N_width +: N_width] <= dut_out;
            if (r_beat == LAST_BEAT) begin
              r_beat       <= '0;
              r_dut_op_val <= '0;
              r_rsp_valid  <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end else begin
            r_rsp_err    <= 1'b1;
            r_rsp_data   <= '0;
            r_beat       <= '0;
            r_dut_op_val <= '0;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end
        end

        // Hold the response stable until the consumer takes it
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready        = r_cmd_ready;
  assign busy             = r_busy;
  assign dut_start        = r_dut_start;
  assign dut_input_enable = r_dut_input_enable;
  assign dut_a            = r_dut_a;
  assign dut_b            = r_dut_b;
  assign dut_op_val       = r_dut_op_val;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_data         = r_rsp_data;
  assign rsp_err          = r_rsp_err;

endmodule

// File: tb/tb_fsm_nibble_host.sv
// Directed bench for fsm_nibble_host. The compute FSM is replaced by a
// behavioural output-burst driver; expected responses are queued when the
// burst (or the timeout condition) is set up and popped when rsp_valid rises.

module tb_fsm_nibble_host;

  localparam int N       = 64;
  localparam int NW      = 4;
  localparam int OPS_MAX = 8;
  localparam int TIMEOUT = 16;
  localparam int BEATS   = N / NW;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [N-1:0]      cmd_a;
  logic [N-1:0]      cmd_b;
  logic [15:0]       cmd_op_seq;
  logic [3:0]        cmd_op_len;
  logic [1:0]        cmd_op_tail;
  logic              dut_start;
  logic              dut_input_enable;
  logic [NW-1:0]     dut_a;
  logic [NW-1:0]     dut_b;
  logic [1:0]        dut_op_val;
  logic              dut_output_valid;
  logic [NW-1:0]     dut_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;

  typedef struct packed {
    logic         err;
    logic [N-1:0] data;
  } rsp_t;

  rsp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  fsm_nibble_host #(
    .N       (N),
    .N_width (NW),
    .OPS_MAX (OPS_MAX),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_a            (cmd_a),
    .cmd_b            (cmd_b),
    .cmd_op_seq       (cmd_op_seq),
    .cmd_op_len       (cmd_op_len),
    .cmd_op_tail      (cmd_op_tail),
    .dut_start        (dut_start),
    .dut_input_enable (dut_input_enable),
    .dut_a            (dut_a),
    .dut_b            (dut_b),
    .dut_op_val       (dut_op_val),
    .dut_output_valid (dut_output_valid),
    .dut_out          (dut_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the middle (falling edge) of the next cycle
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"},
          {cmd_ready, busy, rsp_valid, rsp_err, dut_start, dut_input_enable,
           dut_op_val, dut_a, dut_b},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0});
    check({tag, "_data"}, rsp_data, '0);
  endtask

  // Offer a command in the current IDLE cycle; returns in cycle T+1
  task automatic send_cmd(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [15:0] seq, input logic [3:0] len,
                          input logic [1:0] tail);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_a       = a;
    cmd_b       = b;
    cmd_op_seq  = seq;
    cmd_op_len  = len;
    cmd_op_tail = tail;
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
    check("start_cycle", {dut_start, dut_input_enable, busy, cmd_ready}, 4'b1010);
  endtask

  // LOAD cycles T+2..T+1+BEATS
  task automatic check_load(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int k = 0; k < BEATS; k++) begin
      tick();
      check($sformatf("load_beat%0d", k),
            {dut_start, dut_input_enable, dut_op_val, dut_a, dut_b},
            {1'b0, 1'b1, 2'b00, a[k*NW +: NW], b[k*NW +: NW]});
    end
  endtask

  // Behavioural FSM output: drive beats first..first+count-1 of data
  task automatic burst(input logic [N-1:0] data, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      dut_output_valid = 1'b1;
      dut_out          = data[k*NW +: NW];
      tick();
    end
    dut_output_valid = 1'b0;
    dut_out          = '0;
  endtask

  // Wait (bounded) for rsp_valid and compare against the scoreboard head
  task automatic expect_rsp(input string tag);
    rsp_t exp;
    int   n = 0;
    while (!rsp_valid && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_sb_nonempty"}, sb_q.size() != 0, 1'b1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check({tag, "_rsp_data"}, rsp_data, exp.data);
      check({tag, "_rsp_err"}, rsp_err, exp.err);
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_back_idle"}, {cmd_ready, busy, rsp_valid}, 3'b100);
  endtask

  // Command a=5 b=3, op[0]=2, tail=1, result 7
  task automatic run_basic(input string tag);
    rsp_t e;
    send_cmd(64'd5, 64'd3, 16'h0002, 4'd1, 2'd1);
    check_load(64'd5, 64'd3);
    tick();
    check({tag, "_ops0"}, {dut_input_enable, dut_op_val}, 3'b0_10);
    tick();
    check({tag, "_wait_tail"}, {dut_op_val, rsp_valid}, 3'b01_0);
    tick();
    tick();
    e.err  = 1'b0;
    e.data = 64'h7;
    sb_q.push_back(e);
    burst(64'h7, 0, BEATS - 1);
    check({tag, "_no_early_rsp"}, rsp_valid, 1'b0);
    burst(64'h7, BEATS - 1, 1);
    check({tag, "_rsp_at_x_plus_beats"}, rsp_valid, 1'b1);
    expect_rsp(tag);
    handshake(tag);
  endtask

  initial begin
    rsp_t e;
    logic [N-1:0] d_hold;
    logic [15:0]  seq8;

    cmd_valid        = 1'b0;
    cmd_a            = '0;
    cmd_b            = '0;
    cmd_op_seq       = '0;
    cmd_op_len       = '0;
    cmd_op_tail      = '0;
    dut_output_valid = 1'b0;
    dut_out          = '0;
    rsp_ready        = 1'b0;
    rst              = 1'b1;
    #2 rst = 1'b0;

    // Reset values while rst is low
    tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();

    // Basic loopback-style transaction
    run_basic("basic");

    // Short burst: 5 valid beats then a gap
    send_cmd(64'hAAAA_5555_AAAA_5555, 64'h1234_5678_9ABC_DEF0, 16'h0000, 4'd0, 2'd3);
    check_load(64'hAAAA_5555_AAAA_5555, 64'h1234_5678_9ABC_DEF0);
    tick();
    check("short_wait_tail", {dut_input_enable, dut_op_val}, 3'b0_11);
    e.err  = 1'b1;
    e.data = '0;
    sb_q.push_back(e);
    burst(64'hFFFF_FFFF_FFFF_FFFF, 0, 5);
    check("short_drop_cycle", rsp_valid, 1'b0);
    tick();
    check("short_rsp_next", rsp_valid, 1'b1);
    expect_rsp("short");
    handshake("short");

    // Response back-pressure, then a queued command with op_len above OPS_MAX
    d_hold = 64'h0123_4567_89AB_CDEF;
    send_cmd(64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 16'h0000, 4'd0, 2'd1);
    check_load(64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0);
    tick();
    e.err  = 1'b0;
    e.data = d_hold;
    sb_q.push_back(e);
    burst(d_hold, 0, BEATS);
    expect_rsp("hold");
    seq8        = 16'b10_01_11_00_01_10_00_11;
    cmd_a       = 64'h1111_2222_3333_4444;
    cmd_b       = 64'h5555_6666_7777_8888;
    cmd_op_seq  = seq8;
    cmd_op_len  = 4'd15;
    cmd_op_tail = 2'd2;
    cmd_valid   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("hold_ctrl%0d", c), {rsp_valid, rsp_err, cmd_ready, busy}, 4'b1001);
      check($sformatf("hold_data%0d", c), rsp_data, d_hold);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hold_idle_after_hs", {cmd_ready, rsp_valid, busy}, 3'b100);
    tick();
    cmd_valid = 1'b0;
    check("clamp_start", {dut_start, busy}, 2'b11);
    check_load(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    for (int i = 0; i < OPS_MAX; i++) begin
      tick();
      check($sformatf("clamp_op%0d", i), {dut_input_enable, dut_op_val},
            {1'b0, seq8[2*i +: 2]});
    end
    tick();
    check("clamp_tail", dut_op_val, 2'd2);
    e.err  = 1'b0;
    e.data = 64'hCAFE_F00D_DEAD_BEEF;
    sb_q.push_back(e);
    burst(64'hCAFE_F00D_DEAD_BEEF, 0, BEATS);
    expect_rsp("clamp");
    handshake("clamp");

    // Reset in the middle of LOAD (beat 7), then a fresh command
    send_cmd(64'd5, 64'd3, 16'h0002, 4'd1, 2'd1);
    for (int k = 0; k < 8; k++) tick();
    check("midload_beat7", {dut_input_enable, dut_a}, {1'b1, 4'h0});
    rst = 1'b0;
    tick();
    check_reset_vals("midload_reset");
    rst = 1'b1;
    tick();
    run_basic("after_reset");

    // Tail op that never produces output
    send_cmd(64'hFEDC_BA98_7654_3210, 64'h0, 16'h0000, 4'd0, 2'd2);
    check_load(64'hFEDC_BA98_7654_3210, 64'h0);
    tick();
`ifdef FSM_NIBBLE_HOST_TIMEOUT_EN
    e.err  = 1'b1;
    e.data = '0;
    sb_q.push_back(e);
    for (int w = 1; w <= TIMEOUT; w++) begin
      check($sformatf("timeout_wait%0d", w), {rsp_valid, busy, dut_op_val}, 4'b0_1_10);
      tick();
    end
    check("timeout_rsp_cycle", rsp_valid, 1'b1);
    expect_rsp("timeout");
    handshake("timeout");
`else
    for (int w = 0; w < 40; w++) tick();
    check("unbounded_wait", {rsp_valid, busy, dut_op_val}, 4'b0_1_10);
    rst = 1'b0;
    tick();
    check_reset_vals("unbounded_reset");
    rst = 1'b1;
    tick();
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_nibble_host.md
# fsm_nibble_host

Host-side initiator for the 4-bit nibble-serial compute FSM interface. The block accepts one wide command (`a`, `b` operands and a short op_val sequence) and drives the FSM's start, input_enable, nibble and op_val pins. It then collects the nibble-serial result while output_valid is high and returns it as one wide response. It sits between on-chip/testbench command logic and the `fsm_design` pin interface, either as a loopback driver or for board-level bring-up.

## Interface
- `N`, 64, operand/result width in bits.
- `N_width`, 4, nibble width; `N` must be a power-of-two multiple of `N_width`; `BEATS = N/N_width`.
- `OPS_MAX`, 8, maximum op_val steps per command.
- `TIMEOUT`, 1024, maximum WAIT cycles before error (used only with the macro enabled).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_a`, `cmd_b` in N: operands; beat k is bits [k*N_width +: N_width].
- `cmd_op_seq` in 2*OPS_MAX: op i is bits [2i +: 2].
- `cmd_op_len` in $clog2(OPS_MAX+1): number of ops; values above OPS_MAX are clamped to OPS_MAX.
- `cmd_op_tail` in 2: op_val held after the sequence until output starts.
- `dut_start`, `dut_input_enable` out 1: FSM controls.
- `dut_a`, `dut_b` out N_width: nibble lanes.
- `dut_op_val` out 2: op select.
- `dut_output_valid` in 1, `dut_out` in N_width: FSM result lane.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_data` out N: assembled result.
- `rsp_err` out 1: error flag (timeout or short burst).
- `busy` out 1: high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE: go to START on `cmd_valid`. On that edge, latch all cmd_* fields into registers.
  - START: `dut_start`=1 for exactly 1 cycle, then go to LOAD.
  - LOAD: runs BEATS cycles with beat counter k=0..BEATS-1.
    - `dut_input_enable`=1 every LOAD cycle.
    - `dut_a`/`dut_b` carry beat k of the latched operands.
    - After beat BEATS-1, go to OPS, or to WAIT if op_len=0.
  - OPS: one cycle per op; `dut_op_val` = op i. After op_len-1, go to WAIT.
  - WAIT: `dut_op_val` = op_tail. Go to COLLECT on the first cycle with `dut_output_valid`=1; that same cycle captures beat 0.
  - COLLECT: on each cycle with `dut_output_valid`=1, write `dut_out` into `rsp_data[k*N_width +: N_width]` and increment k.
    - After beat BEATS-1 is captured, go to RESP.
    - If `dut_output_valid`=0 before BEATS beats are captured: `rsp_err`=1, `rsp_data` cleared to 0, go to RESP.
  - RESP: `rsp_valid`=1. `rsp_data`/`rsp_err` stay stable until `rsp_ready`, then go to IDLE.
- Output values by state:
  - `dut_op_val` = 0 in IDLE/START/LOAD/RESP.
  - `dut_a`/`dut_b` = 0 outside LOAD.
  - `rsp_data` is cleared on command accept.
- All dut_* outputs are decodes of registered state and counters. There is no combinational path from any input to any dut_* output.
- Counters: the beat counter is $clog2(BEATS) bits and does not wrap within a phase. The op counter is $clog2(OPS_MAX+1) bits.
- Reset:
  - Values while `rst` is low: state IDLE, all counters 0, `rsp_data` 0, `rsp_err` 0, `rsp_valid` 0, all dut_* outputs 0, `busy` 0, `cmd_ready` 1.
  - Reset mid-operation abandons the command with no response. The FSM is reset by the same `rst`.

## Timing
- With the command accepted at edge T:
  - `dut_start` is high in cycle T+1.
  - LOAD runs cycles T+2..T+1+BEATS; this matches the FSM's 1-cycle IDLE→INPUT step and its BEATS-cycle INPUT phase.
  - OPS runs cycles T+2+BEATS..T+1+BEATS+op_len.
- If `dut_output_valid` first rises in cycle X: beats are captured in X..X+BEATS-1, and `rsp_valid` is high from cycle X+BEATS.
- `cmd_ready` returns in the cycle after the `rsp_valid`&`rsp_ready` edge. Minimum command spacing is therefore 3+BEATS+op_len+wait+BEATS cycles.

## Configuration
- `FSM_NIBBLE_HOST_TIMEOUT_EN` defined:
  - A WAIT-cycle counter of $clog2(TIMEOUT+1) bits runs while in WAIT.
  - If TIMEOUT cycles pass in WAIT without `dut_output_valid`: `rsp_err`=1, `rsp_data`=0, go to RESP.
  - The counter is cleared on entry to WAIT.
- Not defined: WAIT is unbounded, and `rsp_err` is set only on a short burst.

## Test plan
- Loopback with `fsm_design` (N=64): a=5, b=3, op_len=1, op[0]=2, tail=1 -> FSM path S0→S4→OUTPUT; `rsp_data`=64'h7, `rsp_err`=0; `dut_start` at T+1; 16 LOAD cycles at T+2..T+17.
- Loopback with a=64'hFEDC_BA98_7654_3210, b=0, op_len=0, tail=2 -> sequence skipped, FSM goes S0→S4, then tail 2 holds it in S4, so `rsp_valid` never rises; with the macro and TIMEOUT=16, `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 on WAIT cycle 17.
- Behavioural FSM model asserting `dut_output_valid` for 5 cycles then dropping -> `rsp_err`=1, `rsp_data`=0, `rsp_valid` in the cycle after the drop.
- `rsp_ready` held 0 for 10 cycles in RESP -> `rsp_valid`, `rsp_data`, `rsp_err` constant; `cmd_ready`=0; second `cmd_valid` ignored until the handshake.
- `rst` low at LOAD beat 7 -> next cycle all outputs at reset values, `cmd_ready`=1; a fresh command then completes correctly.
- `cmd_op_len`=15 with OPS_MAX=8 -> exactly 8 OPS cycles driving op[0..7] in order.
